// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to the
// pixel/colour controllers.
//   pixel_en   - one-clk pulse per pixel (master clock / CLK_DIV)
//   hCount     - horizontal position
//   vCount     - vertical position
//   hSync      - horizontal sync, active low
//   vSync      - vertical sync, active low
//   bright     - inside the visible area
//   frame_tick - one-clk pulse at the start of vertical blank
//   frame_cnt  - free-running 8-bit frame count
// master: the timing generator (drives everything); slave: the consumers.
interface vga_timing_gen_if;
    logic       pixel_en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       frame_tick;
    logic [7:0] frame_cnt;

    modport master (
        output pixel_en, hCount, vCount, hSync, vSync, bright, frame_tick, frame_cnt
    );

    modport slave (
        input pixel_en, hCount, vCount, hSync, vSync, bright, frame_tick, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing source.
// Divides clk by CLK_DIV into a pixel enable, runs the horizontal/vertical
// counters and produces registered active-low syncs, the bright flag, a
// once-per-frame tick (entering vertical blank) and an 8-bit frame counter.
// Ports:
//   clk - master clock
//   rst - asynchronous, active-high reset
//   vga - vga_timing_gen_if.master, all timing outputs (every one a flop)
// Optional build macro VGA_SYNC_DELAY_EN: hSync/vSync/bright pass through one
// extra pixel_en-enabled stage so they lag hCount/vCount by one pixel.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_DISP_START = 144,
    parameter int unsigned H_DISP_END   = 784,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_DISP_START = 35,
    parameter int unsigned V_DISP_END   = 515
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_gen_if.master   vga
);

    localparam logic [3:0] DivMax     = 4'(CLK_DIV - 1);
    localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0] HSyncEnd   = 10'(H_SYNC);
    localparam logic [9:0] HDispStart = 10'(H_DISP_START);
    localparam logic [9:0] HDispEnd   = 10'(H_DISP_END);
    localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
    localparam logic [9:0] VSyncEnd   = 10'(V_SYNC);
    localparam logic [9:0] VDispStart = 10'(V_DISP_START);
    localparam logic [9:0] VDispEnd   = 10'(V_DISP_END);

    logic [3:0] div_q, div_d;
    logic       pixel_en_q, pixel_en_d;
    logic [9:0] h_count_q, h_count_d;
    logic [9:0] v_count_q, v_count_d;
    logic       h_sync_q, h_sync_d;
    logic       v_sync_q, v_sync_d;
    logic       bright_q, bright_d;
    logic       frame_tick_q, frame_tick_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        div_d        = (div_q == DivMax) ? 4'd0 : div_q + 4'd1;
        pixel_en_d   = (div_q == DivMax);
        h_count_d    = h_count_q;
        v_count_d    = v_count_q;
        h_sync_d     = h_sync_q;
        v_sync_d     = v_sync_q;
        bright_d     = bright_q;
        frame_tick_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        if (pixel_en_q) begin
            if (h_count_q == HLast) begin
                h_count_d = 10'd0;
                v_count_d = (v_count_q == VLast) ? 10'd0 : v_count_q + 10'd1;
            end else begin
                h_count_d = h_count_q + 10'd1;
            end
            // Decoded from the next counts so the flags line up with the
            // counters they are presented alongside.
            h_sync_d = !(h_count_d < HSyncEnd);
            v_sync_d = !(v_count_d < VSyncEnd);
            bright_d = (h_count_d >= HDispStart) && (h_count_d < HDispEnd) &&
                       (v_count_d >= VDispStart) && (v_count_d < VDispEnd);
            if ((h_count_d == 10'd0) && (v_count_d == VDispEnd)) begin
                frame_tick_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= 4'd0;
            pixel_en_q   <= 1'b0;
            h_count_q    <= 10'd0;
            v_count_q    <= 10'd0;
            h_sync_q     <= 1'b0;
            v_sync_q     <= 1'b0;
            bright_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            div_q        <= div_d;
            pixel_en_q   <= pixel_en_d;
            h_count_q    <= h_count_d;
            v_count_q    <= v_count_d;
            h_sync_q     <= h_sync_d;
            v_sync_q     <= v_sync_d;
            bright_q     <= bright_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    // One-pixel retiming stage to match downstream synchronous ROM latency.
    logic h_sync_dly_q, h_sync_dly_d;
    logic v_sync_dly_q, v_sync_dly_d;
    logic bright_dly_q, bright_dly_d;

    always_comb begin
        h_sync_dly_d = h_sync_dly_q;
        v_sync_dly_d = v_sync_dly_q;
        bright_dly_d = bright_dly_q;
        if (pixel_en_q) begin
            h_sync_dly_d = h_sync_q;
            v_sync_dly_d = v_sync_q;
            bright_dly_d = bright_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_sync_dly_q <= 1'b0;
            v_sync_dly_q <= 1'b0;
            bright_dly_q <= 1'b0;
        end else begin
            h_sync_dly_q <= h_sync_dly_d;
            v_sync_dly_q <= v_sync_dly_d;
            bright_dly_q <= bright_dly_d;
        end
    end

    assign vga.hSync  = h_sync_dly_q;
    assign vga.vSync  = v_sync_dly_q;
    assign vga.bright = bright_dly_q;
`else
    assign vga.hSync  = h_sync_q;
    assign vga.vSync  = v_sync_q;
    assign vga.bright = bright_q;
`endif

    assign vga.pixel_en   = pixel_en_q;
    assign vga.hCount     = h_count_q;
    assign vga.vCount     = v_count_q;
    assign vga.frame_tick = frame_tick_q;
    assign vga.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized self-checking bench for vga_timing_gen.
// Uses a shrunken raster so many whole frames (and the frame_cnt wrap) fit in
// a short run. Expected outputs are derived arithmetically from the number of
// clock edges since reset release.
module tb_vga_timing_gen;

    localparam int D   = 3;
    localparam int HT  = 8;
    localparam int HS  = 2;
    localparam int HDS = 3;
    localparam int HDE = 7;
    localparam int VT  = 6;
    localparam int VS  = 1;
    localparam int VDS = 2;
    localparam int VDE = 5;
    localparam int F   = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   k = 0;  // clock edges since reset release

    always #5 clk = ~clk;

    vga_timing_gen_if vga ();

    vga_timing_gen #(
        .CLK_DIV     (D),
        .H_TOTAL     (HT),
        .H_SYNC      (HS),
        .H_DISP_START(HDS),
        .H_DISP_END  (HDE),
        .V_TOTAL     (VT),
        .V_SYNC      (VS),
        .V_DISP_START(VDS),
        .V_DISP_END  (VDE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(vga)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, got, exp, $time, k);
        end
    endtask

    // {pixel_en, hCount, vCount, hSync, vSync, bright, frame_tick, frame_cnt}
    function automatic logic [32:0] model(input int kk);
        int         n, pos, pp;
        logic       pen, hs, vs, br, ft;
        logic [9:0] hc, vc;
        logic [7:0] fc;
        pen = (kk > 0) && (kk % D == 0);
        n   = (kk >= 1) ? (kk - 1) / D : 0;  // pixel advances so far
        pos = n % F;
        hc  = 10'(pos % HT);
        vc  = 10'(pos / HT);
        pp  = pos;
`ifdef VGA_SYNC_DELAY_EN
        pp  = (n == 0) ? -1 : (n - 1) % F;
`endif
        hs = (pp >= 0) && ((pp % HT) >= HS);
        vs = (pp >= 0) && ((pp / HT) >= VS);
        br = (pp >= 0) && ((pp % HT) >= HDS) && ((pp % HT) < HDE) &&
             ((pp / HT) >= VDS) && ((pp / HT) < VDE);
        ft = (kk > 1) && ((kk - 1) % D == 0) && (pos == VDE * HT);
        fc = (n >= VDE * HT) ? 8'(((n - VDE * HT) / F + 1) % 256) : 8'd0;
        return {pen, hc, vc, hs, vs, br, ft, fc};
    endfunction

    function automatic logic [32:0] actual();
        return {vga.pixel_en, vga.hCount, vga.vCount, vga.hSync, vga.vSync,
                vga.bright, vga.frame_tick, vga.frame_cnt};
    endfunction

    int ticks = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) k++;
        if (vga.frame_tick) ticks++;
        check_val("outs", {31'd0, actual()}, {31'd0, model(k)});
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (n_err > 20) break;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        k   = 0;
        #1;
        check_val("async_rst", {31'd0, actual()}, 64'd0);
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int limit;
        bit hit;
        repeat (3) step();
        check_val("rst_pixel_en", {63'd0, vga.pixel_en}, 64'd0);
        check_val("rst_hcount", {54'd0, vga.hCount}, 64'd0);
        check_val("rst_vcount", {54'd0, vga.vCount}, 64'd0);
        check_val("rst_hsync", {63'd0, vga.hSync}, 64'd0);
        check_val("rst_vsync", {63'd0, vga.vSync}, 64'd0);
        check_val("rst_bright", {63'd0, vga.bright}, 64'd0);
        check_val("rst_frame_tick", {63'd0, vga.frame_tick}, 64'd0);
        check_val("rst_frame_cnt", {56'd0, vga.frame_cnt}, 64'd0);

        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        ticks = 0;
        // Long enough for 256+ frames so frame_cnt wraps.
        run(257 * F * D + VDE * HT * D + 5);
        check_val("tick_total", 64'(ticks), 64'(257 + 1));
        check_val("cnt_after_wrap", {56'd0, vga.frame_cnt}, 64'd2);

        // Reset mid-frame at a chosen position, then random positions.
        hit = 1'b0;
        for (int i = 0; i < 2 * F * D; i++) begin
            if (n_err > 20) break;
            step();
            if (vga.hCount == 10'd5 && vga.vCount == 10'd3) begin
                hit = 1'b1;
                break;
            end
        end
        check_val("reach_pos", {63'd0, hit}, 64'd1);
        do_reset();
        run(3 * F * D);
        for (int r = 0; r < 5; r++) begin
            if (n_err > 20) break;
            limit = int'($urandom_range(20, 4 * F * D));
            run(limit);
            do_reset();
            run(int'($urandom_range(D * HT, 2 * F * D)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
